// File: rtl/pipe_stage_chain_pkg.sv
// Shared defaults and helpers for the pipeline-register chain.
// Imported by the interface, the stage register and the top.
package pipe_stage_chain_pkg;

    localparam int DEF_STAGES = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 5;
    localparam int DEF_CNT_W  = 16;

    // Register tag 0 is hard-wired, so it never forwards.
    localparam int TAG_ZERO = 0;

    function automatic int idx_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer-side and consumer-side handshake of the chain, bundled together.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid never depends on ready.
interface pipe_stage_chain_if
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_rd;
    logic              in_regwrite;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_rd;
    logic              out_regwrite;

    modport slave (
        input  in_valid, in_data, in_rd, in_regwrite, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_regwrite
    );

    modport master (
        output in_valid, in_data, in_rd, in_regwrite, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_regwrite
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid/data/rd/regwrite registers.
// Priority is flush > hold > load; a flush clears only the valid bit.
module pipe_stage_reg
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_rd,
    input  logic              load_regwrite,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  rd,
    output logic              regwrite
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            data     <= '0;
            rd       <= '0;
            regwrite <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid    <= load_valid;
            data     <= load_data;
            rd       <= load_rd;
            regwrite <= load_regwrite;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Configurable-depth pipeline register chain with hold propagation,
// per-stage flush, youngest-first forwarding lookup and a stall counter.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    pipe_stage_chain_if.slave           bus,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    input  logic [TAG_W-1:0]            q_a,
    input  logic [TAG_W-1:0]            q_b,
    output logic                        fwd_a_hit,
    output logic                        fwd_b_hit,
    output logic [DATA_W-1:0]           fwd_a_data,
    output logic [DATA_W-1:0]           fwd_b_data,
    output logic [idx_w(STAGES)-1:0]    fwd_a_stage,
    output logic [idx_w(STAGES)-1:0]    fwd_b_stage,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int IDX_W = idx_w(STAGES);

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] regwrite;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] load_valid;
    logic [DATA_W-1:0] data    [STAGES];
    logic [TAG_W-1:0]  rd      [STAGES];
    logic [DATA_W-1:0] ld_data [STAGES];
    logic [TAG_W-1:0]  ld_rd   [STAGES];
    logic [STAGES-1:0] ld_regwrite;
    logic              in_ready;

    // Hold ripples from the oldest stage back; an empty unstalled stage breaks it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1] | (valid[STAGES-1] & ~bus.out_ready);
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | (valid[i] & hold[i+1]);
        end
    end

    assign in_ready     = ~hold[0];
    assign bus.in_ready = in_ready;

    // A stage whose predecessor is held receives a bubble.
    always_comb begin
        load_valid    = '0;
        load_valid[0] = bus.in_valid & in_ready;
        for (int i = 1; i < STAGES; i++) begin
            load_valid[i] = valid[i-1] & ~hold[i-1];
        end
    end

    assign ld_data[0]     = bus.in_data;
    assign ld_rd[0]       = bus.in_rd;
    assign ld_regwrite[0] = bus.in_regwrite;

    for (genvar g = 1; g < STAGES; g++) begin : g_link
        assign ld_data[g]     = data[g-1];
        assign ld_rd[g]       = rd[g-1];
        assign ld_regwrite[g] = regwrite[g-1];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .flush         (flush[g]),
            .hold          (hold[g]),
            .load_valid    (load_valid[g]),
            .load_data     (ld_data[g]),
            .load_rd       (ld_rd[g]),
            .load_regwrite (ld_regwrite[g]),
            .valid         (valid[g]),
            .data          (data[g]),
            .rd            (rd[g]),
            .regwrite      (regwrite[g])
        );
    end

    assign bus.out_valid    = valid[STAGES-1];
    assign bus.out_data     = data[STAGES-1];
    assign bus.out_rd       = rd[STAGES-1];
    assign bus.out_regwrite = regwrite[STAGES-1];

    // Scan oldest to youngest so the youngest matching producer overwrites last.
    always_comb begin
        fwd_a_hit   = 1'b0;
        fwd_a_data  = '0;
        fwd_a_stage = '0;
        fwd_b_hit   = 1'b0;
        fwd_b_data  = '0;
        fwd_b_stage = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid[i] && regwrite[i] && (rd[i] == q_a) && (q_a != TAG_W'(TAG_ZERO))) begin
                fwd_a_hit   = 1'b1;
                fwd_a_data  = data[i];
                fwd_a_stage = IDX_W'(i);
            end
            if (valid[i] && regwrite[i] && (rd[i] == q_b) && (q_b != TAG_W'(TAG_ZERO))) begin
                fwd_b_hit   = 1'b1;
                fwd_b_data  = data[i];
                fwd_b_stage = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
